mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 22 ++
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder_ram.sv | 40 ++++
 rtl/mem_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder data-memory responder.
// Package name is mem_resp_pkg; imported by the top-level responder.
package mem_resp_pkg;

  // Width of the RAM latency countdown (LAT legal range 1..15).
  localparam int LAT_W = 4;

  // Width of the IO acknowledge timeout counter (TIMEOUT legal range 1..255).
  localparam int TMO_W = 8;

  // Read data returned when an IO load never sees io_ack.
  localparam logic [15:0] IO_TIMEOUT_DATA = 16'hDEAD;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAM_WAIT = 2'd1,
    ST_IO_REQ   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// External IO space bus used by mem_responder.
// master: the responder issuing requests; slave: the IO target answering them.
interface mem_responder_if;

  logic        io_req;
  logic        io_we;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic        io_ack;
  logic [15:0] io_rdata;

  modport master (
    output io_req,
    output io_we,
    output io_addr,
    output io_wdata,
    input  io_ack,
    input  io_rdata
  );

  modport slave (
    input  io_req,
    input  io_we,
    input  io_addr,
    input  io_wdata,
    output io_ack,
    output io_rdata
  );

endinterface

// File: rtl/mem_responder_ram.sv
// mem_resp_ram: single-port synchronous 16-bit RAM of DEPTH words.
// Writes on en & we; registered read on en & ~we. The read register holds its
// value between reads, so the last load result stays visible. DEPTH >= 2.
module mem_resp_ram #(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] idx;

  // Word index wraps modulo DEPTH.
  assign idx = AW'(addr % DEPTH);

  // Storage array write port; contents are not affected by reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Registered read port, holding the last read word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 16'h0000;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: services EX_MEM load/store requests from local RAM (fixed
// latency LAT) or the external IO space (variable latency, TIMEOUT bound),
// holding the pipeline with stall until the access completes.
// Optional feature macro: MEM_RESP_POSTED_WRITE_EN -- RAM stores are written
// straight from IDLE at the next edge without stalling.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LAT     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_re,
  input  logic        Mem_we,
  input  logic        Mem_sel,
  input  logic [15:0] d_addr,
  input  logic [15:0] wrt_data,
  output logic        stall,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        err,
  mem_responder_if.master io
);

  localparam bit LAT_ONE = (LAT == 1);

  state_t             state_r;
  logic [LAT_W-1:0]   lat_cnt_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [15:0]        addr_r;
  logic [15:0]        wdata_r;
  logic               store_r;
  logic               load_r;
  logic               io_req_r;
  logic               io_we_r;
  logic [15:0]        io_addr_r;
  logic [15:0]        io_wdata_r;
  logic [15:0]        rd_hold_r;
  logic               rd_src_ram_r;
  logic               rd_valid_r;
  logic               err_r;

  logic               req_s;
  logic               posted_s;
  logic               ram_last_s;
  logic               stall_s;
  logic               ram_en_s;
  logic               ram_we_s;
  logic [15:0]        ram_addr_s;
  logic [15:0]        ram_wdata_s;
  logic [15:0]        ram_q_s;

  assign req_s      = Mem_re | Mem_we;
  // Final RAM_WAIT cycle: the RAM is accessed at the edge that leaves it.
  assign ram_last_s = (lat_cnt_r < LAT_W'(2));

`ifdef MEM_RESP_POSTED_WRITE_EN
  assign posted_s = ~Mem_sel & Mem_we;
`else
  assign posted_s = 1'b0;
`endif

  // Stall: raised in the accepting IDLE cycle and throughout the wait states.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE:     stall_s = req_s & ~posted_s;
      ST_RAM_WAIT: stall_s = 1'b1;
      ST_IO_REQ:   stall_s = 1'b1;
      ST_DONE:     stall_s = 1'b0;
      default:     stall_s = 1'b0;
    endcase
  end

  // RAM port steering: direct from the request in IDLE, from latched request later.
  always_comb begin
    ram_en_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = addr_r;
    ram_wdata_s = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s && !Mem_sel && (posted_s || LAT_ONE)) begin
          ram_en_s    = 1'b1;
          ram_we_s    = Mem_we;
          ram_addr_s  = d_addr;
          ram_wdata_s = wrt_data;
        end else begin
          ram_en_s    = 1'b0;
        end
      end
      ST_RAM_WAIT: begin
        if (ram_last_s) begin
          ram_en_s = 1'b1;
          ram_we_s = store_r;
        end else begin
          ram_en_s = 1'b0;
        end
      end
      default: ram_en_s = 1'b0;
    endcase
  end

  // Access sequencer with registered responses and IO bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      lat_cnt_r    <= '0;
      tmo_cnt_r    <= '0;
      addr_r       <= 16'h0000;
      wdata_r      <= 16'h0000;
      store_r      <= 1'b0;
      load_r       <= 1'b0;
      io_req_r     <= 1'b0;
      io_we_r      <= 1'b0;
      io_addr_r    <= 16'h0000;
      io_wdata_r   <= 16'h0000;
      rd_hold_r    <= 16'h0000;
      rd_src_ram_r <= 1'b0;
      rd_valid_r   <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            // Simultaneous load and store is serviced as a store and flagged.
            if (Mem_re && Mem_we) begin
              err_r <= 1'b1;
            end
            addr_r  <= d_addr;
            wdata_r <= wrt_data;
            store_r <= Mem_we;
            load_r  <= Mem_re & ~Mem_we;
            if (Mem_sel) begin
              state_r    <= ST_IO_REQ;
              io_req_r   <= 1'b1;
              io_we_r    <= Mem_we;
              io_addr_r  <= d_addr;
              io_wdata_r <= wrt_data;
              tmo_cnt_r  <= '0;
            end else if (posted_s) begin
              state_r <= ST_IDLE;
            end else if (LAT_ONE) begin
              state_r <= ST_DONE;
              if (Mem_re && !Mem_we) begin
                rd_valid_r   <= 1'b1;
                rd_src_ram_r <= 1'b1;
              end
            end else begin
              state_r   <= ST_RAM_WAIT;
              lat_cnt_r <= LAT_W'(LAT - 1);
            end
          end
        end
        ST_RAM_WAIT: begin
          if (ram_last_s) begin
            state_r <= ST_DONE;
            if (load_r) begin
              rd_valid_r   <= 1'b1;
              rd_src_ram_r <= 1'b1;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          end
        end
        ST_IO_REQ: begin
          if (io.io_ack) begin
            io_req_r <= 1'b0;
            state_r  <= ST_DONE;
            if (load_r) begin
              rd_hold_r    <= io.io_rdata;
              rd_src_ram_r <= 1'b0;
              rd_valid_r   <= 1'b1;
            end
          end else if (tmo_cnt_r >= TMO_W'(TIMEOUT - 1)) begin
            io_req_r <= 1'b0;
            err_r    <= 1'b1;
            state_r  <= ST_DONE;
            if (load_r) begin
              rd_hold_r    <= IO_TIMEOUT_DATA;
              rd_src_ram_r <= 1'b0;
              rd_valid_r   <= 1'b1;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  mem_resp_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en_s & rst_n),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_q_s)
  );

  // Reset forces stall low even while a request is still presented.
  assign stall       = stall_s & rst_n;
  assign rd_data     = rd_src_ram_r ? ram_q_s : rd_hold_r;
  assign rd_valid    = rd_valid_r;
  assign err         = err_r;
  assign io.io_req   = io_req_r;
  assign io.io_we    = io_we_r;
  assign io.io_addr  = io_addr_r;
  assign io.io_wdata = io_wdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (LAT=2, TIMEOUT=8, DEPTH=4096).
// Load results are pushed into a scoreboard queue at issue time and checked
// by an independent monitor whenever rd_valid pulses.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Mem_re = 1'b0;
  logic        Mem_we = 1'b0;
  logic        Mem_sel = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] wrt_data = 16'h0000;
  logic        stall;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        err;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

`ifdef MEM_RESP_POSTED_WRITE_EN
  localparam int ST_STALL = 0;
`else
  localparam int ST_STALL = 2;
`endif

  mem_responder_if bus();

  mem_responder #(
    .DEPTH   (4096),
    .LAT     (2),
    .TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Mem_re   (Mem_re),
    .Mem_we   (Mem_we),
    .Mem_sel  (Mem_sel),
    .d_addr   (d_addr),
    .wrt_data (wrt_data),
    .stall    (stall),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .err      (err),
    .io       (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One pipeline access; counts stall and io_req cycles, acks on io_req cycle ack_at (0 = never).
  task automatic access(input logic re, input logic we, input logic sel,
                        input logic [15:0] a, input logic [15:0] wd,
                        input int ack_at, input logic [15:0] rdat,
                        output int st_cyc, output int rq_cyc);
    int guard;
    bit done;
    @(posedge clk); #1;
    Mem_re = re; Mem_we = we; Mem_sel = sel; d_addr = a; wrt_data = wd;
    st_cyc = 0; rq_cyc = 0; done = 0; guard = 0;
    while (!done && guard < 64) begin
      @(negedge clk);
      guard++;
      if (bus.io_req) begin
        rq_cyc++;
        if (rq_cyc == 1) begin
          chk("io_addr", {16'h0, bus.io_addr}, {16'h0, a});
          chk("io_we", {31'h0, bus.io_we}, {31'h0, we});
          if (we) chk("io_wdata", {16'h0, bus.io_wdata}, {16'h0, wd});
        end
      end
      if (bus.io_req && rq_cyc == ack_at) begin
        bus.io_ack = 1'b1;
        bus.io_rdata = rdat;
      end else begin
        bus.io_ack = 1'b0;
      end
      if (stall) st_cyc++;
      else done = 1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_done: stall still high after %0d cycles, required release", guard);
    end
    @(posedge clk); #1;
    Mem_re = 1'b0; Mem_we = 1'b0; Mem_sel = 1'b0; bus.io_ack = 1'b0;
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expected load.
  initial forever begin
    logic [15:0] e;
    @(negedge clk);
    if (rst_n && rd_valid) begin
      chk("stall_in_done", {31'h0, stall}, 32'h0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got data %h, required no response", rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", {16'h0, rd_data}, {16'h0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, rq;
    bus.io_ack = 1'b0;
    bus.io_rdata = 16'h0000;

    // Reset state
    @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_io_req", {31'h0, bus.io_req}, 32'h0);
    chk("rst_io_we", {31'h0, bus.io_we}, 32'h0);
    chk("rst_rd_data", {16'h0, rd_data}, 32'h0);
    chk("rst_io_addr", {16'h0, bus.io_addr}, 32'h0);
    chk("rst_io_wdata", {16'h0, bus.io_wdata}, 32'h0);
    rst_n = 1'b1;

    // RAM store then load
    access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h1234, 0, 16'h0, st, rq);
    chk("store_stall", st, ST_STALL);
    exp_q.push_back(16'h1234);
    access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 0, 16'h0, st, rq);
    chk("load_stall", st, 2);
    chk("load_io_req", rq, 0);
    @(negedge clk);
    chk("rd_data_hold", {16'h0, rd_data}, 32'h1234);
    chk("rd_valid_pulse", {31'h0, rd_valid}, 32'h0);

    // Address wraps modulo DEPTH: 0x1010 aliases 0x0010
    access(1'b0, 1'b1, 1'b0, 16'h1010, 16'hABCD, 0, 16'h0, st, rq);
    exp_q.push_back(16'hABCD);
    access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 0, 16'h0, st, rq);
    chk("alias_load_stall", st, 2);

    // IO load, ack on 5th request cycle
    exp_q.push_back(16'hBEEF);
    access(1'b1, 1'b0, 1'b1, 16'hC000, 16'h0, 5, 16'hBEEF, st, rq);
    chk("io_load_stall", st, 6);
    chk("io_load_req", rq, 5);
    @(negedge clk);
    chk("io_rd_hold", {16'h0, rd_data}, 32'hBEEF);

    // IO store, ack in first request cycle
    access(1'b0, 1'b1, 1'b1, 16'hC004, 16'h5A5A, 1, 16'h0, st, rq);
    chk("io_store_stall", st, 2);
    chk("io_store_req", rq, 1);

    // Stray ack while idle is ignored
    bus.io_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ack_stall", {31'h0, stall}, 32'h0);
    chk("stray_ack_req", {31'h0, bus.io_req}, 32'h0);
    bus.io_ack = 1'b0;
    chk("err_clean", {31'h0, err}, 32'h0);

    // Load and store together: store wins, err set
    access(1'b1, 1'b1, 1'b0, 16'h0004, 16'h00FF, 0, 16'h0, st, rq);
    chk("both_stall", st, ST_STALL);
    chk("both_err", {31'h0, err}, 32'h1);
    exp_q.push_back(16'h00FF);
    access(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0, 0, 16'h0, st, rq);

    // Reset clears err but not RAM contents
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_err", {31'h0, err}, 32'h0);
    chk("rst2_rd_data", {16'h0, rd_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'h00FF);
    access(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0, 0, 16'h0, st, rq);
    chk("ram_kept_stall", st, 2);

`ifndef MEM_RESP_POSTED_WRITE_EN
    // Reset during RAM_WAIT of a store abandons it
    @(posedge clk); #1;
    Mem_we = 1'b1; Mem_sel = 1'b0; d_addr = 16'h0004; wrt_data = 16'h7777;
    @(negedge clk);
    chk("mid_stall_before", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_stall_reset", {31'h0, stall}, 32'h0);
    Mem_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'h00FF);
    access(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0, 0, 16'h0, st, rq);
    chk("mid_reload_stall", st, 2);
`else
    // Three back-to-back posted stores, never stalling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      Mem_we = 1'b1; Mem_sel = 1'b0;
      d_addr = 16'h0020 + 16'(i);
      wrt_data = 16'h1111 * 16'(i + 1);
      @(negedge clk);
      chk("posted_stall", {31'h0, stall}, 32'h0);
    end
    @(posedge clk); #1;
    Mem_we = 1'b0;
    exp_q.push_back(16'h1111);
    access(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 0, 16'h0, st, rq);
    exp_q.push_back(16'h2222);
    access(1'b1, 1'b0, 1'b0, 16'h0021, 16'h0, 0, 16'h0, st, rq);
    exp_q.push_back(16'h3333);
    access(1'b1, 1'b0, 1'b0, 16'h0022, 16'h0, 0, 16'h0, st, rq);
    chk("posted_load_stall", st, 2);
`endif

    // IO load with no ack: times out after 8 request cycles
    exp_q.push_back(16'hDEAD);
    access(1'b1, 1'b0, 1'b1, 16'hC100, 16'h0, 0, 16'h1111, st, rq);
    chk("tmo_stall", st, 9);
    chk("tmo_req", rq, 8);
    chk("tmo_err", {31'h0, err}, 32'h1);
    exp_q.push_back(16'hABCD);
    access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 0, 16'h0, st, rq);
    chk("err_sticky", {31'h0, err}, 32'h1);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
